// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port SPRAM arbiter: FSM encoding, port indices
// and default bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_READ  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Client-side request/response bundle for both ports plus the SPRAM port.
// slave = arbiter view, master = clients + memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        output ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
               mem_addr, mem_write, mem_data_in
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        input  ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
               mem_addr, mem_write, mem_data_in
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Two-way request selector. Round-robin on ties when MEM_ARB_ROUND_ROBIN_EN is
// defined, otherwise fixed priority to port 0 (last_i ignored).
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic vld_o,
    output logic idx_o
);
    assign vld_o = req0_i | req1_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        idx_o = PORT0;
        if (req0_i && req1_i) idx_o = ~last_i;
        else if (req1_i)      idx_o = PORT1;
    end
`else
    logic unused_last;
    assign unused_last = last_i;
    assign idx_o = req0_i ? PORT0 : PORT1;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two clients onto the single SPRAM port, one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: port 0 wins).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    arb_state_e                   state_q;
    logic                         owner_q;
    logic [1:0]                   ack_q;
    logic [1:0]                   rvalid_q;
    logic [1:0][DATA_W-1:0]       rdata_q;
    logic [ADDR_W-1:0]            mem_addr_q;
    logic                         mem_write_q;
    logic [DATA_W-1:0]            mem_data_in_q;

    logic [1:0]                   req, we;
    logic [1:0][ADDR_W-1:0]       addr;
    logic [1:0][DATA_W-1:0]       wdata;
    logic                         pick_vld, pick_idx, last_port;

    assign req   = {bus.req1, bus.req0};
    assign we    = {bus.we1, bus.we0};
    assign addr  = {bus.addr1, bus.addr0};
    assign wdata = {bus.wdata1, bus.wdata0};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Reset to PORT1 so the first tie after reset goes to port 0.
    always_ff @(posedge clk) begin
        if (rst)                              last_q <= PORT1;
        else if (state_q == ST_IDLE && pick_vld) last_q <= pick_idx;
    end
    assign last_port = last_q;
`else
    assign last_port = PORT1;
`endif

    mem_arb_pick u_pick (
        .req0_i (req[0]),
        .req1_i (req[1]),
        .last_i (last_port),
        .vld_o  (pick_vld),
        .idx_o  (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= PORT0;
            ack_q         <= '0;
            rvalid_q      <= '0;
            rdata_q       <= '0;
            mem_addr_q    <= '0;
            mem_write_q   <= 1'b0;
            mem_data_in_q <= '0;
        end else begin
            ack_q    <= '0;
            rvalid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        mem_addr_q      <= addr[pick_idx];
                        mem_write_q     <= we[pick_idx];
                        mem_data_in_q   <= wdata[pick_idx];
                        owner_q         <= pick_idx;
                        ack_q[pick_idx] <= 1'b1;
                        state_q         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // mem samples the access at the end of this cycle
                    mem_write_q <= 1'b0;
                    state_q     <= mem_write_q ? ST_IDLE : ST_READ;
                end
                ST_READ: begin
                    rdata_q[owner_q]  <= bus.mem_data_out;
                    rvalid_q[owner_q] <= 1'b1;
                    state_q           <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack0        = ack_q[0];
    assign bus.ack1        = ack_q[1];
    assign bus.rvalid0     = rvalid_q[0];
    assign bus.rvalid1     = rvalid_q[1];
    assign bus.rdata0      = rdata_q[0];
    assign bus.rdata1      = rdata_q[1];
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // SPRAM: registered read, data valid the cycle after the address is sampled
    logic [DW-1:0] spram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_write) spram[bus.mem_addr] <= bus.mem_data_in;
        bus.mem_data_out <= spram[bus.mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timeline view: an access accepted at edge k blocks new acceptance until
    // k+2 (write) or k+3 (read); a read's data appears after edge k+2.
    function automatic bit model_pick(input bit r0, input bit r1, input bit last);
        if (r0 && r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return !last;
`else
            return 1'b0;
`endif
        end
        return r1 && !r0;
    endfunction

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            edge_n = 0, next_free = 0, rd_due = -1;
    bit            rd_port, m_last = 1'b1, m_seen = 1'b0;
    logic [DW-1:0] rd_val;
    logic [1:0]    m_ack, m_rvalid;
    logic [DW-1:0] m_rdata [2];
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;

    bit            m_w, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    assign m_w     = model_pick(bus.req0, bus.req1, m_last);
    assign s_we    = m_w ? bus.we1 : bus.we0;
    assign s_addr  = m_w ? bus.addr1 : bus.addr0;
    assign s_wdata = m_w ? bus.wdata1 : bus.wdata0;

    always @(posedge clk) begin
        edge_n   <= edge_n + 1;
        m_seen   <= 1'b1;
        m_ack    <= '0;
        m_rvalid <= '0;
        m_we     <= 1'b0;
        if (rst) begin
            m_addr     <= '0;
            m_wdata    <= '0;
            m_rdata[0] <= '0;
            m_rdata[1] <= '0;
            next_free  <= edge_n + 1;
            rd_due     <= -1;
            m_last     <= 1'b1;
        end else begin
            if (rd_due == edge_n) begin
                m_rvalid[rd_port] <= 1'b1;
                m_rdata[rd_port]  <= rd_val;
            end
            if (edge_n >= next_free && (bus.req0 || bus.req1)) begin
                m_ack[m_w] <= 1'b1;
                m_addr     <= s_addr;
                m_we       <= s_we;
                m_wdata    <= s_wdata;
                m_last     <= m_w;
                if (s_we) begin
                    ref_mem[s_addr] <= s_wdata;
                    next_free       <= edge_n + 2;
                end else begin
                    rd_due    <= edge_n + 2;
                    rd_port   <= m_w;
                    rd_val    <= ref_mem[s_addr];
                    next_free <= edge_n + 3;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_seen) begin
            chk("ack0",        32'(bus.ack0),        32'(m_ack[0]));
            chk("ack1",        32'(bus.ack1),        32'(m_ack[1]));
            chk("rvalid0",     32'(bus.rvalid0),     32'(m_rvalid[0]));
            chk("rvalid1",     32'(bus.rvalid1),     32'(m_rvalid[1]));
            chk("rdata0",      32'(bus.rdata0),      32'(m_rdata[0]));
            chk("rdata1",      32'(bus.rdata1),      32'(m_rdata[1]));
            chk("mem_addr",    32'(bus.mem_addr),    32'(m_addr));
            chk("mem_write",   32'(bus.mem_write),   32'(m_we));
            chk("mem_data_in", 32'(bus.mem_data_in), 32'(m_wdata));
        end
    end

    // ---------------- event log ----------------
    int            ncyc = 0;
    int            ack_log [$];
    int            rv1_cyc [$];
    logic [DW-1:0] rv1_dat [$];
    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (bus.ack0) ack_log.push_back(0);
        if (bus.ack1) ack_log.push_back(1);
        if (bus.rvalid1) begin
            rv1_cyc.push_back(ncyc);
            rv1_dat.push_back(bus.rdata1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
        else   begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
    endtask

    task automatic release_port(input bit p);
        if (p) begin bus.req1 = 1'b0; bus.we1 = 1'b0; end
        else   begin bus.req0 = 1'b0; bus.we0 = 1'b0; end
    endtask

    // Holds the request until ack is seen (bounded); returns cycles waited.
    task automatic issue(input bit p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int waited);
        bit got;
        drive(p, we, a, d);
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 20) begin
            @(negedge clk);
            waited++;
            got = p ? bus.ack1 : bus.ack0;
        end
        if (!got) chk("ack_timeout", 0, 1);
        release_port(p);
    endtask

    logic [AW-1:0] pool [6] = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd5, 15'h7FFF};

    initial begin
        int wt;
        bit pend [2];
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack0",      32'(bus.ack0),      0);
        chk("rst_mem_write", 32'(bus.mem_write), 0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  0);
        rst = 1'b0;
        @(negedge clk);

        // write 0x58 to 5 on port 0, read back on port 1
        issue(1'b0, 1'b1, 15'd5, 8'h58, wt);
        chk("t1_ack_lat",   32'(wt), 1);
        chk("t1_mem_write", 32'(bus.mem_write), 1);
        chk("t1_mem_addr",  32'(bus.mem_addr), 5);
        chk("t1_mem_data",  32'(bus.mem_data_in), 'h58);
        @(negedge clk);
        chk("t1_we_pulse",  32'(bus.mem_write), 0);
        issue(1'b1, 1'b0, 15'd5, 8'h00, wt);
        chk("t1_rd_ack_lat", 32'(wt), 1);
        @(negedge clk);
        chk("t1_rvalid_early", 32'(bus.rvalid1), 0);
        @(negedge clk);
        chk("t1_rvalid1", 32'(bus.rvalid1), 1);
        chk("t1_rdata1",  32'(bus.rdata1), 'h58);

        // back-to-back writes 'A'..'D', then reads
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b1, 15'(i), 8'('h41 + i), wt);
            if (i > 0) chk("t2_wr_ack_spacing", 32'(wt), 2);
        end
        rv1_cyc.delete();
        rv1_dat.delete();
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, 15'(i), 8'h00, wt);
            if (i > 0) chk("t2_rd_ack_spacing", 32'(wt), 3);
        end
        repeat (4) @(negedge clk);
        chk("t2_rv_count", 32'(rv1_cyc.size()), 4);
        for (int i = 0; i < rv1_cyc.size() && i < 4; i++) begin
            chk("t2_rdata", 32'(rv1_dat[i]), 32'('h41 + i));
            if (i > 0) chk("t2_rv_spacing", 32'(rv1_cyc[i] - rv1_cyc[i-1]), 3);
        end

        // reset during the READ cycle of a port 1 read
        issue(1'b1, 1'b0, 15'd5, 8'h00, wt);
        @(negedge clk);
        chk("t4_no_rvalid_yet", 32'(bus.rvalid1), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rvalid1",   32'(bus.rvalid1),    0);
        chk("t4_ack1",      32'(bus.ack1),       0);
        chk("t4_rdata1",    32'(bus.rdata1),     0);
        chk("t4_rdata0",    32'(bus.rdata0),     0);
        chk("t4_mem_addr",  32'(bus.mem_addr),   0);
        chk("t4_mem_write", 32'(bus.mem_write),  0);
        chk("t4_mem_data",  32'(bus.mem_data_in), 0);
        rst = 1'b0;
        issue(1'b0, 1'b0, 15'd2, 8'h00, wt);
        chk("t4_post_ack_lat", 32'(wt), 1);
        @(negedge clk);
        chk("t4_post_rvalid1", 32'(bus.rvalid1), 0);
        @(negedge clk);
        chk("t4_post_rvalid0", 32'(bus.rvalid0), 1);
        chk("t4_post_rdata0",  32'(bus.rdata0), 'h43);

        // both ports hold reads continuously after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ack_log.delete();
        drive(1'b0, 1'b0, 15'd0, 8'h00);
        drive(1'b1, 1'b0, 15'd5, 8'h00);
        repeat (13) @(negedge clk);
        release_port(1'b0);
        release_port(1'b1);
        @(negedge clk);
        chk("t3_ack_count", 32'(ack_log.size()), 5);
        for (int i = 0; i < ack_log.size(); i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk("t3_rr_order", 32'(ack_log[i]), 32'(i % 2));
`else
            chk("t3_fixed_port0", 32'(ack_log[i]), 0);
`endif
        end
        repeat (3) @(negedge clk);

        // top address boundary
        issue(1'b0, 1'b1, 15'h7FFF, 8'hA5, wt);
        issue(1'b1, 1'b0, 15'h7FFF, 8'h00, wt);
        repeat (2) @(negedge clk);
        chk("t5_rvalid1", 32'(bus.rvalid1), 1);
        chk("t5_rdata1",  32'(bus.rdata1), 'hA5);
        issue(1'b0, 1'b0, 15'd0, 8'h00, wt);
        repeat (2) @(negedge clk);
        chk("t5_rvalid0", 32'(bus.rvalid0), 1);
        chk("t5_addr0_rdata0", 32'(bus.rdata0), 'h41);

        // random traffic against the model
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && ((p == 1) ? bus.ack1 : bus.ack0)) pend[p] = 1'b0;
                if (!pend[p]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        pend[p] = 1'b1;
                        drive(1'(p), 1'($urandom_range(1, 0)), pool[$urandom_range(5, 0)],
                              8'($urandom_range(255, 0)));
                    end else begin
                        release_port(1'(p));
                    end
                end
            end
            @(negedge clk);
        end
        release_port(1'b0);
        release_port(1'b1);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the byte-wide SPRAM `mem` block. Accepts independent read/write requests from two clients, such as a memory loader and a UART dump sequencer. It serialises the requests onto the single `mem` port and returns read data to the requester that issued it. The block sits between the clients and `mem` and owns `mem`'s addr/write/data_in inputs exclusively.

## Interface
- `ADDR_W`, default 15: byte address width (matches `mem`).
- `DATA_W`, default 8: data width.

- `clk`  in  1  system clock (12 MHz)
- `rst`  in  1  synchronous, active-high reset
- `req0`/`req1`  in  1  request valid, per requester
- `we0`/`we1`  in  1  1 = write, 0 = read
- `addr0`/`addr1`  in  ADDR_W  byte address
- `wdata0`/`wdata1`  in  DATA_W  write data
- `ack0`/`ack1`  out  1  request accepted, one-cycle pulse
- `rvalid0`/`rvalid1`  out  1  read data valid, one-cycle pulse
- `rdata0`/`rdata1`  out  DATA_W  read data, held until the next read completes for that port
- `mem_addr`  out  ADDR_W  to `mem.addr`
- `mem_write`  out  1  to `mem.write`
- `mem_data_in`  out  DATA_W  to `mem.data_in`
- `mem_data_out`  in  DATA_W  from `mem.data_out`, valid one cycle after the address is sampled

## Operation
- FSM with states IDLE, ISSUE, READ. Only one transaction is in flight at a time.
- **IDLE:**
  - No `req`: stay. `mem_write` = 0.
  - Any `req`: pick the winner and register `mem_addr` <= `addrN`, `mem_write` <= `weN`, `mem_data_in` <= `wdataN`.
  - Also set `owner` <= N, `ackN` <= 1, and go to ISSUE.
- **ISSUE:**
  - `mem` samples the access at the end of this cycle.
  - `mem_write` <= 0, `ackN` <= 0.
  - A write goes to IDLE; a read goes to READ.
  - `req` inputs are not sampled in this state.
- **READ:** `rdata_owner` <= `mem_data_out`, `rvalid_owner` <= 1, then go to IDLE.
- **Requester rule:**
  - Hold `req`/`we`/`addr`/`wdata` stable until `ack` is seen.
  - On the edge where `ack` is high, deassert `req` or present the next request.
- Address arithmetic is not performed. Addresses pass through unchanged; 0x7FFF is legal.
- **Arbitration:**
  - With one requester active, it wins.
  - With both active, the winner is decided by the configuration below.
- **Reset:**
  - Takes effect at any state, including mid-READ. The pending read is dropped and no `rvalid` is issued.
  - Outputs: all `ack`/`rvalid` = 0, `rdata` = 0, `mem_addr` = 0, `mem_write` = 0, `mem_data_in` = 0.
  - State returns to IDLE; the round-robin pointer is set to favour port 0.

## Timing
- `req` sampled at edge E0 -> `ack` and the `mem_*` signals are visible in cycle E0..E1.
- `mem` performs the access at E1.
- For reads, `mem_data_out` is valid E1..E2; `rvalid`/`rdata` are visible E2..E3.
- **Throughput:**
  - A write occupies 2 cycles and a read 3.
  - IDLE re-arbitrates in the same cycle that `rvalid` is high.
- Read latency is 1 cycle from `req` sample to `ack` and 3 cycles from `req` sample to `rvalid`.
- `mem_write` is high for exactly one cycle per write.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, the port not served last wins.
  - The pointer updates on every acceptance.
  - Continuous requests from both ports are granted alternately.
- Undefined:
  - Fixed priority; port 0 always wins ties.
  - Port 1 can starve while `req0` stays high.
  - The pointer register is not implemented.

## Structure
- Package `mem_arb_pkg`:
  - FSM state encoding (IDLE/ISSUE/READ).
  - Port index constants `PORT0`/`PORT1`.
  - Default `ADDR_W`/`DATA_W`.
- One sub-module, `mem_arb_pick`: combinational two-way selector that takes `req0`, `req1` and `last`, and outputs a valid winner plus its index. The round-robin vs fixed-priority choice lives inside it under the macro.

## Test plan
- Port 0 writes addr 5 data 0x58:
  - `ack0` is high exactly one cycle after sampling.
  - `mem_write` is high one cycle with `mem_addr` = 5 and `mem_data_in` = 0x58.
  - Port 1 then reads addr 5: `rvalid1` with `rdata1` = 0x58 arrives 2 cycles after `ack1`.
- Port 0 writes 'A'..'D' back-to-back at addresses 0..3; port 1 then reads 0..3:
  - `ack0` spacing is 2 cycles.
  - Reads return 0x41..0x44 in order, with `rvalid` spacing of 3 cycles.
- Both ports hold read requests continuously with the macro defined: acks alternate 0,1,0,1…, and the first grant after reset goes to port 0.
- Same stimulus with the macro undefined: only `ack0` pulses, and `ack1` never rises while `req0` is high.
- `rst` asserted during the READ cycle of a port 1 read:
  - No `rvalid1`.
  - The next cycle has all outputs at their reset values and the state is IDLE.
  - A subsequent request is accepted normally.
- Write 0xA5 to addr 0x7FFF, then read it back: returns 0xA5, and addr 0 is unaffected.
